// File: rtl/iterative_alu_if.sv
// ---------------------------------------------------------------------------
// iterative_alu_if
//   Operation/result bundle between the execute-stage issue logic and the
//   iterative ALU.
//
//   start_i    : operation valid, sampled by the ALU only while busy_o = 0
//   ALUCtrl_i  : 3-bit operation code from the ALU control decoder
//   data1_i    : operand A (rs1)
//   data2_i    : operand B (rs2 or sign-extended immediate)
//   data_o     : registered result, held until the next completion
//   zero_o     : registered, 1 when the value written to data_o is zero
//   done_o     : one-cycle pulse, data_o valid in that cycle
//   busy_o     : high while a multiply is in progress (pipeline stall)
//
//   master : issue side (drives operation, observes result)
//   slave  : the ALU itself
// ---------------------------------------------------------------------------
interface iterative_alu_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;
  logic             done_o;
  logic             busy_o;

  modport master (
    output start_i, ALUCtrl_i, data1_i, data2_i,
    input  data_o, zero_o, done_o, busy_o
  );

  modport slave (
    input  start_i, ALUCtrl_i, data1_i, data2_i,
    output data_o, zero_o, done_o, busy_o
  );
endinterface

// File: rtl/iterative_alu.sv
// ---------------------------------------------------------------------------
// iterative_alu
//   Execute-stage ALU. Logic, shift and add/sub operations complete one clock
//   edge after acceptance. Multiply runs a fixed WIDTH-iteration shift-add
//   loop and holds busy_o high for the whole loop so the hazard unit can
//   stall the upstream pipeline registers.
//
//   clk_i : clock, all state updates on the rising edge
//   rst_i : asynchronous, active-high reset
//   bus   : iterative_alu_if.slave (operation in, result/handshake out)
// ---------------------------------------------------------------------------
module iterative_alu #(
  parameter int WIDTH = 32
) (
  input logic            clk_i,
  input logic            rst_i,
  iterative_alu_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  // Count value seen on the edge that completes the final iteration.
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SRAI = 3'b111;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] acc_next;
  logic [SHW-1:0]   shamt;

  // Shift amounts use only the low bits of operand B, so the srai
  // immediate's funct7 bit (B[10]) never reaches the shifter.
  assign shamt = bus.data2_i[SHW-1:0];

  // NOTE: every signal written in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    result = '0;
    case (bus.ALUCtrl_i)
      OP_AND:          result = bus.data1_i & bus.data2_i;
      OP_XOR:          result = bus.data1_i ^ bus.data2_i;
      OP_SLL:          result = bus.data1_i << shamt;
      OP_ADD, OP_ADDI: result = bus.data1_i + bus.data2_i;
      OP_SUB:          result = bus.data1_i - bus.data2_i;
      OP_SRAI:         result = $unsigned($signed(bus.data1_i) >>> shamt);
      OP_MUL:          result = '0; // handled by the iterative datapath
      default:         result = '0;
    endcase
  end

  // One shift-add step; the low WIDTH bits are the same for signed and
  // unsigned operands, so no sign handling is needed.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  assign bus.busy_o = (state == S_MUL);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  // NOTE: the multiply datapath registers are reset along with the control
  // state; they are few, and reset keeps them free of X after power-up.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      bus.data_o <= '0;
      bus.zero_o <= 1'b0;
      bus.done_o <= 1'b0;
    end else begin
      bus.done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            if (bus.ALUCtrl_i == OP_MUL) begin
              mcand  <= bus.data1_i;
              mplier <= bus.data2_i;
              acc    <= '0;
              cnt    <= '0;
              state  <= S_MUL;
            end else begin
              bus.data_o <= result;
              bus.zero_o <= (result == '0);
              bus.done_o <= 1'b1;
            end
          end
        end
        S_MUL: begin
          // start_i is ignored here; upstream is stalled by busy_o.
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_ITER) begin
            bus.data_o <= acc_next;
            bus.zero_o <= (acc_next == '0);
            bus.done_o <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// ---------------------------------------------------------------------------
// tb_iterative_alu
//   Directed bench for iterative_alu. Each accepted operation pushes its
//   expected result onto a scoreboard queue; a monitor pops and compares on
//   every done_o pulse. Handshake timing (busy length, done latency/width,
//   reset behaviour) is checked inline.
// ---------------------------------------------------------------------------
module tb_iterative_alu;

  localparam int W = 32;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_SRAI = 3'b111;

  typedef struct {
    logic [W-1:0] data;
    logic         zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  iterative_alu_if #(.WIDTH(W)) bus ();

  iterative_alu #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference: plain operators, multiply via '*'.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      OP_AND:          return a & b;
      OP_XOR:          return a ^ b;
      OP_SLL:          return a << sh;
      OP_ADD, OP_ADDI: return a + b;
      OP_SUB:          return a - b;
      OP_MUL:          return a * b;
      default:         return $unsigned($signed(a) >>> sh);
    endcase
  endfunction

  // Scoreboard monitor: every done_o pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done_o === 1'b1) begin
      check("done_has_pending_op", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", bus.data_o, e.data);
        check("sb_zero", {31'b0, bus.zero_o}, {31'b0, e.zero});
      end
    end
  end

  // Drive one operation for one cycle (accepted at the next rising edge).
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp);
    exp_t e;
    @(negedge clk);
    #1;
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = op;
    bus.data1_i   = a;
    bus.data2_i   = b;
    e.data = exp;
    e.zero = (exp == '0);
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  // Called right after issuing a mul. Counts busy cycles (bounded) and
  // optionally keeps hammering start_i with adds that must be ignored.
  task automatic wait_mul(input bit hold_add, input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy_o !== 1'b1) break;
      n++;
      #1;
      if (hold_add && n < 20) begin
        bus.start_i   = 1'b1;
        bus.ALUCtrl_i = OP_ADD;
        bus.data1_i   = 32'(n);
        bus.data2_i   = 32'd100;
      end else begin
        bus.start_i = 1'b0;
      end
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd32);
    check({tag, "_done_at_busy_fall"}, {31'b0, bus.done_o}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;

    rst           = 1'b1;
    bus.start_i   = 1'b0;
    bus.ALUCtrl_i = OP_AND;
    bus.data1_i   = '0;
    bus.data2_i   = '0;

    repeat (2) @(negedge clk);
    check("rst_data", bus.data_o, 32'd0);
    check("rst_zero", {31'b0, bus.zero_o}, 32'd0);
    check("rst_done", {31'b0, bus.done_o}, 32'd0);
    check("rst_busy", {31'b0, bus.busy_o}, 32'd0);
    #1 rst = 1'b0;

    // add 5+7: done exactly one cycle, one edge after acceptance
    issue(OP_ADD, 32'd5, 32'd7, 32'd12);
    idle();
    check("add_done_latency", {31'b0, bus.done_o}, 32'd1);
    @(negedge clk);
    check("add_done_width", {31'b0, bus.done_o}, 32'd0);
    check("add_data_hold", bus.data_o, 32'd12);

    // Back-to-back single-cycle ops
    issue(OP_SUB,  32'd7,         32'd7,         32'd0);
    issue(OP_SRAI, 32'h8000_0000, 32'h0000_0404, 32'hF800_0000);
    issue(OP_SLL,  32'd1,         32'd31,        32'h8000_0000);
    issue(OP_XOR,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F);
    idle();
    repeat (3) @(negedge clk);
    check("xor_data_hold", bus.data_o, 32'hF00F_F00F);
    check("xor_zero_hold", {31'b0, bus.zero_o}, 32'd0);

    // Multiplies
    issue(OP_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
    wait_mul(1'b0, "mul_neg1x3");
    issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0);
    wait_mul(1'b0, "mul_wrap_zero");
    issue(OP_MUL, 32'd6, 32'd7, 32'd42);
    wait_mul(1'b1, "mul_ignore_start");

    // Random single-cycle ops back to back, then a random multiply
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op == OP_MUL) op = OP_ADDI;
      a = $urandom;
      b = $urandom;
      issue(op, a, b, model(op, a, b));
    end
    idle();
    a = $urandom;
    b = $urandom;
    issue(OP_MUL, a, b, model(OP_MUL, a, b));
    wait_mul(1'b0, "mul_random");

    // Reset at iteration 10 of a mul: immediate clear, no done for it
    issue(OP_XOR, 32'h0000_1234, 32'd0, 32'h0000_1234);
    idle();
    @(negedge clk);
    #1;
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = OP_MUL;
    bus.data1_i   = 32'h1234_5678;
    bus.data2_i   = 32'h9ABC_DEF1;
    @(negedge clk);
    #1 bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", {31'b0, bus.busy_o}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_data", bus.data_o, 32'd0);
    check("async_rst_zero", {31'b0, bus.zero_o}, 32'd0);
    check("async_rst_done", {31'b0, bus.done_o}, 32'd0);
    check("async_rst_busy", {31'b0, bus.busy_o}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    issue(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    idle();
    check("and_done_latency", {31'b0, bus.done_o}, 32'd1);

    // Long quiet window: any stray done_o is caught by the monitor
    repeat (40) @(negedge clk);
    check("post_rst_busy", {31'b0, bus.busy_o}, 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
# iterative_alu

Execute-stage ALU for the pipelined RV32 subset CPU. It consumes the 3-bit operation code produced by the ALU control decoder together with both operands. Single-cycle operations return a result after one clock edge. `mul` runs on a 32-iteration shift-add datapath and raises `busy_o` so the hazard logic can stall the upstream pipeline registers.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width; `mul` iteration count equals `WIDTH`.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `start_i`  in  1  operation valid; sampled only when `busy_o`=0.
- `ALUCtrl_i`  in  3  operation code, encoded as follows:
  - 000 `and`, 001 `xor`, 010 `sll`, 011 `add`
  - 100 `sub`, 101 `mul`, 110 `addi`, 111 `srai`
- `data1_i`  in  WIDTH  operand A (rs1).
- `data2_i`  in  WIDTH  operand B (rs2 or sign-extended immediate).
- `data_o`  out  WIDTH  registered result; holds until the next completion.
- `zero_o`  out  1  registered; 1 when the value written to `data_o` is 0.
- `done_o`  out  1  one-cycle pulse; `data_o` is valid in that cycle.
- `busy_o`  out  1  1 while a `mul` is in progress; drives the pipeline stall.

## Operation
States:
- IDLE: default state.
- MUL: multiplication in progress.

In IDLE with `start_i`=1 and a non-`mul` code:
- Result computed combinationally from the operands and registered into `data_o`; `done_o`=1 next cycle.
- State stays IDLE.

In IDLE with `start_i`=1 and `mul`:
- Load registers: `mcand`=A, `mplier`=B, `acc`=0, `cnt`=0.
- Go to MUL.

Each MUL cycle:
- If `mplier[0]`=1, `acc` += `mcand` (modulo 2^WIDTH).
- `mcand` <<= 1; `mplier` >>= 1 (logical); `cnt` += 1.
- The edge that completes iteration WIDTH writes the final `acc` into `data_o`, pulses `done_o`, and returns the state to IDLE.
- No early termination; latency is fixed.

Arithmetic rules:
- `add`/`addi`: A+B; `sub`: A−B; all wrap modulo 2^WIDTH, no overflow flag.
- `sll`: A << B[4:0].
- `srai`: arithmetic (sign-filling) shift A >>> B[4:0]. Only B[4:0] is used, so B[10]=1 from the immediate encoding is ignored.
- `mul`: low WIDTH bits of A×B, identical for signed and unsigned operands.
- `busy_o` = (state == MUL), decoded from the state register.
- `start_i` during MUL is ignored. Upstream must hold the instruction stalled, so there is no queueing.
- `zero_o` updates only on completion edges.

## Timing
- Reset values: `data_o`=0, `zero_o`=0, `done_o`=0, `busy_o`=0, state IDLE, `cnt`=0.
- Single-cycle op accepted at edge E0: `done_o`=1 during the cycle after E0 and is 0 otherwise.
- Back-to-back single-cycle ops: accepted every cycle, with `done_o` held high on consecutive cycles.
- `mul` accepted at E0:
  - `busy_o`=1 from just after E0 through edge E32 (32 cycles).
  - `data_o` is written at E32 and `done_o`=1 for one cycle after E32.
  - A new op may be accepted at E33; during the `done_o` cycle the block is IDLE and can accept at that cycle's end edge.
- Between completions `data_o` and `zero_o` hold their values.
- `rst_i` asserted mid-`mul`: outputs and state return to reset values immediately (asynchronous). No `done_o` is ever produced for the aborted op.
- `start_i`=1 with an undriven or unknown code is outside the contract. Every 3-bit code is defined, so all codes must synthesize.

## Test plan
- Reset, then `add` A=5, B=7 → `data_o`=12, `zero_o`=0, `done_o` high for exactly 1 cycle; then `sub` 7−7 → `data_o`=0, `zero_o`=1.
- `srai` A=0x8000_0000, B=0x0000_0404 → `data_o`=0xF800_0000. `sll` A=1, B=31 → 0x8000_0000. `xor` 0xFF00_FF00 ^ 0x0F0F_0F0F → 0xF00F_F00F.
- `mul` A=0xFFFF_FFFF (−1), B=3:
  - `busy_o` high for 32 cycles.
  - `done_o` 32 edges after accept, `data_o`=0xFFFF_FFFD.
  - Repeat with A=0x0001_0000, B=0x0001_0000 → 0.
- During a `mul`, drive `start_i`=1 with `add` each cycle → ignored. Only the `mul` result appears, and no extra `done_o` pulse.
- Assert `rst_i` at iteration 10 of a `mul` → all outputs 0 immediately and no `done_o`. After release, `and` 0xF0F0_F0F0 & 0xFF00_FF00 → 0xF000_F000 with 1-cycle latency.
